// File: rtl/sys_mm_pkg.sv
// ---------------------------------------------------------------------------
// sys_mm_pkg
// Shared definitions for the 3x3 systolic matrix-multiply sequencer:
//   - state_e       : sequencer state encoding (IDLE/FEED/WAIT/HOLD)
//   - N, FEED_CYCLES, NUM_WAVES : array geometry constants
//   - WAVE_OF_ELEM  : maps row-major product index (3r+c) to its wavefront r+c
// ---------------------------------------------------------------------------
package sys_mm_pkg;

  localparam int N           = 3;
  localparam int FEED_CYCLES = 2 * N - 1;
  localparam int NUM_WAVES   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Product P[r][c] completes on anti-diagonal r+c of the array.
  localparam logic [2:0] WAVE_OF_ELEM [0:8] = '{
    3'd0, 3'd1, 3'd2,
    3'd1, 3'd2, 3'd3,
    3'd2, 3'd3, 3'd4
  };

endpackage

// File: rtl/sys_mm_skew_feeder.sv
// ---------------------------------------------------------------------------
// sys_mm_skew_feeder
// Combinational diagonal-skew selector for the array edges.
// Ports:
//   a_mat, b_mat : 3x3 operand matrices, row-major, element [r][c] at 3r+c
//   t            : feed step (0..4); steps outside the window give zeros
//   arr_a        : lane i = A[i][t-i] when 0 <= t-i <= 2, else 0
//   arr_b        : lane j = B[t-j][j] when 0 <= t-j <= 2, else 0
// ---------------------------------------------------------------------------
module sys_mm_skew_feeder
  import sys_mm_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [9*DATAWIDTH-1:0] a_mat,
  input  logic [9*DATAWIDTH-1:0] b_mat,
  input  logic [2:0]             t,
  output logic [3*DATAWIDTH-1:0] arr_a,
  output logic [3*DATAWIDTH-1:0] arr_b
);

  // Lane l carries inner index k = t-l; OR-merge is safe since at most one k matches.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < N; k++) begin
        arr_a[l*DATAWIDTH +: DATAWIDTH] = arr_a[l*DATAWIDTH +: DATAWIDTH] |
          ((t == 3'(l + k)) ? a_mat[(N*l + k)*DATAWIDTH +: DATAWIDTH] : {DATAWIDTH{1'b0}});
        arr_b[l*DATAWIDTH +: DATAWIDTH] = arr_b[l*DATAWIDTH +: DATAWIDTH] |
          ((t == 3'(l + k)) ? b_mat[(N*k + l)*DATAWIDTH +: DATAWIDTH] : {DATAWIDTH{1'b0}});
      end
    end
  end

endmodule

// File: rtl/systolic_mm_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_mm_sequencer
// Controller for a 3x3 systolic matrix-multiply array. Accepts an operand
// pair, streams it into the array with diagonal skew while holding start,
// captures products per wavefront strobe, and presents the result matrix.
// Ports:
//   CLK, RSTn            : clock (rising edge), async active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   a_mat, b_mat         : operand matrices, row-major
//   arr_start            : array start line (high during FEED and WAIT)
//   arr_a, arr_b         : skewed array edge inputs, lane 0 in LSBs
//   arr_v, arr_p         : wavefront strobes (bit0 = P11v) and products
//   res_valid/res_ready  : result handshake
//   res_mat, res_err     : captured result; err flags a capture timeout
// Optional feature (macro SYS_MM_PERF_CNT_EN):
//   perf_busy : saturating count of cycles spent outside IDLE
//   perf_ops  : wrapping count of error-free results accepted
// ---------------------------------------------------------------------------
module systolic_mm_sequencer
  import sys_mm_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9*DATAWIDTH-1:0]   a_mat,
  input  logic [9*DATAWIDTH-1:0]   b_mat,
  output logic                     arr_start,
  output logic [3*DATAWIDTH-1:0]   arr_a,
  output logic [3*DATAWIDTH-1:0]   arr_b,
  input  logic [4:0]               arr_v,
  input  logic [9*2*DATAWIDTH-1:0] arr_p,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [9*2*DATAWIDTH-1:0] res_mat,
  output logic                     res_err
`ifdef SYS_MM_PERF_CNT_EN
  ,
  output logic [31:0]              perf_busy,
  output logic [15:0]              perf_ops
`endif
);

  localparam int PW = 2 * DATAWIDTH;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                   state_r;
  logic [2:0]               t_r;
  logic [CW-1:0]            wcnt_r;
  logic [9*DATAWIDTH-1:0]   a_r;
  logic [9*DATAWIDTH-1:0]   b_r;
  logic [NUM_WAVES-1:0]     mask_r;
  logic [9*PW-1:0]          res_r;
  logic                     in_ready_r;
  logic                     arr_start_r;
  logic [3*DATAWIDTH-1:0]   arr_a_r;
  logic [3*DATAWIDTH-1:0]   arr_b_r;
  logic                     res_valid_r;
  logic                     res_err_r;

  logic                     accept_s;
  logic                     cap_en_s;
  logic [NUM_WAVES-1:0]     new_mask_s;
  logic [9*DATAWIDTH-1:0]   feed_a_s;
  logic [9*DATAWIDTH-1:0]   feed_b_s;
  logic [2:0]               feed_t_s;
  logic [3*DATAWIDTH-1:0]   skew_a_s;
  logic [3*DATAWIDTH-1:0]   skew_b_s;

  assign accept_s   = in_valid & in_ready_r;
  assign cap_en_s   = (state_r == ST_FEED) || (state_r == ST_WAIT);
  assign new_mask_s = mask_r | (cap_en_s ? arr_v : {NUM_WAVES{1'b0}});

  // Feeder looks one step ahead so the registered edge values line up with t.
  // On accept the operands are not yet registered, so feed straight from the inputs.
  always_comb begin
    feed_a_s = a_r;
    feed_b_s = b_r;
    feed_t_s = t_r + 3'd1;
    if (state_r == ST_IDLE) begin
      feed_a_s = a_mat;
      feed_b_s = b_mat;
      feed_t_s = 3'd0;
    end else begin
      feed_a_s = a_r;
      feed_b_s = b_r;
      feed_t_s = t_r + 3'd1;
    end
  end

  sys_mm_skew_feeder #(.DATAWIDTH(DATAWIDTH)) u_feeder (
    .a_mat (feed_a_s),
    .b_mat (feed_b_s),
    .t     (feed_t_s),
    .arr_a (skew_a_s),
    .arr_b (skew_b_s)
  );

  // Sequencer FSM with all handshake and array-edge outputs registered.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r     <= ST_IDLE;
      t_r         <= 3'd0;
      wcnt_r      <= '0;
      a_r         <= '0;
      b_r         <= '0;
      in_ready_r  <= 1'b0;
      arr_start_r <= 1'b0;
      arr_a_r     <= '0;
      arr_b_r     <= '0;
      res_valid_r <= 1'b0;
      res_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r         <= a_mat;
            b_r         <= b_mat;
            t_r         <= 3'd0;
            state_r     <= ST_FEED;
            in_ready_r  <= 1'b0;
            arr_start_r <= 1'b1;
            arr_a_r     <= skew_a_s;
            arr_b_r     <= skew_b_s;
          end else begin
            in_ready_r  <= 1'b1;
            arr_start_r <= 1'b0;
            arr_a_r     <= '0;
            arr_b_r     <= '0;
          end
        end
        ST_FEED: begin
          if (t_r == 3'(FEED_CYCLES - 1)) begin
            state_r <= ST_WAIT;
            wcnt_r  <= '0;
            arr_a_r <= '0;
            arr_b_r <= '0;
          end else begin
            t_r     <= t_r + 3'd1;
            arr_a_r <= skew_a_s;
            arr_b_r <= skew_b_s;
          end
        end
        ST_WAIT: begin
          if (&new_mask_s) begin
            state_r     <= ST_HOLD;
            arr_start_r <= 1'b0;
            res_valid_r <= 1'b1;
            res_err_r   <= 1'b0;
          end else if (wcnt_r == CW'(TIMEOUT - 1)) begin
            state_r     <= ST_HOLD;
            arr_start_r <= 1'b0;
            res_valid_r <= 1'b1;
            res_err_r   <= 1'b1;
          end else begin
            wcnt_r <= wcnt_r + CW'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
            res_err_r   <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            res_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          arr_start_r <= 1'b0;
          res_valid_r <= 1'b0;
          res_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Product capture: first strobe per wavefront wins; a new operation clears everything.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mask_r <= '0;
      res_r  <= '0;
    end else if (accept_s) begin
      mask_r <= '0;
      res_r  <= '0;
    end else if (cap_en_s) begin
      mask_r <= new_mask_s;
      for (int e = 0; e < N * N; e++) begin
        if (arr_v[WAVE_OF_ELEM[e]] && !mask_r[WAVE_OF_ELEM[e]]) begin
          res_r[e*PW +: PW] <= arr_p[e*PW +: PW];
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign arr_start = arr_start_r;
  assign arr_a     = arr_a_r;
  assign arr_b     = arr_b_r;
  assign res_valid = res_valid_r;
  assign res_mat   = res_r;
  assign res_err   = res_err_r;

`ifdef SYS_MM_PERF_CNT_EN
  logic [31:0] perf_busy_r;
  logic [15:0] perf_ops_r;

  // Activity counters, cleared only by the hardware reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      perf_busy_r <= 32'd0;
      perf_ops_r  <= 16'd0;
    end else begin
      if ((state_r != ST_IDLE) && (perf_busy_r != 32'hFFFF_FFFF)) begin
        perf_busy_r <= perf_busy_r + 32'd1;
      end
      if (res_valid_r && res_ready && !res_err_r) begin
        perf_ops_r <= perf_ops_r + 16'd1;
      end
    end
  end

  assign perf_busy = perf_busy_r;
  assign perf_ops  = perf_ops_r;
`endif

endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// Self-checking bench for systolic_mm_sequencer with a behavioural 3x3
// output-stationary systolic array model and a result scoreboard.
module tb_systolic_mm_sequencer;

  localparam int DW = 8;
  localparam int PW = 16;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          in_valid;
  logic          in_ready;
  logic [71:0]   a_mat;
  logic [71:0]   b_mat;
  logic          arr_start;
  logic [23:0]   arr_a;
  logic [23:0]   arr_b;
  logic [4:0]    arr_v;
  logic [143:0]  arr_p;
  logic          res_valid;
  logic          res_ready;
  logic [143:0]  res_mat;
  logic          res_err;
`ifdef SYS_MM_PERF_CNT_EN
  logic [31:0]   perf_busy;
  logic [15:0]   perf_ops;
`endif

  systolic_mm_sequencer #(.DATAWIDTH(DW), .TIMEOUT(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_start(arr_start), .arr_a(arr_a),
    .arr_b(arr_b), .arr_v(arr_v), .arr_p(arr_p), .res_valid(res_valid),
    .res_ready(res_ready), .res_mat(res_mat), .res_err(res_err)
`ifdef SYS_MM_PERF_CNT_EN
    , .perf_busy(perf_busy), .perf_ops(perf_ops)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural array model ----------------
  logic         model_en;
  logic [4:0]   man_v;
  logic [143:0] man_p;
  logic [7:0]   ain [3][3];
  logic [7:0]   bin [3][3];
  logic [7:0]   pa  [3][3];
  logic [7:0]   pb  [3][3];
  logic [15:0]  acc [3][3];
  logic [4:0]   mv;
  int           s_cnt;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ain[i][0] = arr_a[i*8 +: 8];
      bin[0][i] = arr_b[i*8 +: 8];
      for (int j = 1; j < 3; j++) begin
        ain[i][j] = pa[i][j-1];
        bin[j][i] = pb[j-1][i];
      end
    end
  end

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn || !arr_start) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          acc[i][j] <= 16'd0; pa[i][j] <= 8'd0; pb[i][j] <= 8'd0;
        end
      mv    <= 5'd0;
      s_cnt <= 0;
    end else begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
          pa[i][j]  <= ain[i][j];
          pb[i][j]  <= bin[i][j];
        end
      for (int w = 0; w < 5; w++) mv[w] <= (s_cnt == w + 2);
      s_cnt <= s_cnt + 1;
    end
  end

  assign arr_v = model_en ? mv : man_v;
  always_comb begin
    for (int e = 0; e < 9; e++)
      arr_p[e*PW +: PW] = model_en ? acc[e/3][e%3] : man_p[e*PW +: PW];
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int failures = 0;
  logic [143:0] exp_q[$];
  logic         err_q[$];

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [143:0] mm(input logic [71:0] a, input logic [71:0] b);
    logic [143:0] r;
    logic [15:0]  s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 16'd0;
        for (int k = 0; k < 3; k++) s = s + a[(3*i+k)*8 +: 8] * b[(3*k+j)*8 +: 8];
        r[(3*i+j)*PW +: PW] = s;
      end
    return r;
  endfunction

  function automatic logic [23:0] skew(input logic [71:0] m, input int t, input bit isb);
    logic [23:0] r;
    int k;
    r = '0;
    for (int l = 0; l < 3; l++) begin
      k = t - l;
      if (k >= 0 && k <= 2) r[l*8 +: 8] = isb ? m[(3*k+l)*8 +: 8] : m[(3*l+k)*8 +: 8];
    end
    return r;
  endfunction

  // Offers an operand pair, returns one cycle after the accepting edge (FEED t=0).
  task automatic send(input logic [71:0] a, input logic [71:0] b,
                      input logic [143:0] e, input logic er);
    int n;
    n = 0;
    a_mat = a; b_mat = b; in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("accept_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(e);
    err_q.push_back(er);
  endtask

  task automatic wait_res(input int max);
    int n;
    n = 0;
    while (!res_valid && n < max) begin tick(); n++; end
    chk("res_valid_wait", res_valid, 1);
  endtask

  task automatic take();
    logic [143:0] e;
    logic er;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=%0d required=1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      er = err_q.pop_front();
      chk("res_mat", res_mat, e);
      chk("res_err", res_err, er);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  typedef struct {
    logic [71:0]  a;
    logic [71:0]  b;
    logic [143:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   lane0_exp[5] = '{2, 2, 2, 0, 0};
  int   lane2_exp[5] = '{0, 0, 2, 2, 2};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] e;
    int n;
    RSTn = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    a_mat = '0; b_mat = '0;
    model_en = 1'b1; man_v = 5'd0; man_p = '0;

    // Vector table: identity, constant, two random pairs.
    for (int i = 0; i < 9; i++) begin
      vecs[0].a[i*8 +: 8]    = (i % 4 == 0) ? 8'd1 : 8'd0;
      vecs[0].b[i*8 +: 8]    = 8'(i + 1);
      vecs[0].exp[i*PW +: PW] = 16'(i + 1);
      vecs[1].a[i*8 +: 8]    = 8'd2;
      vecs[1].b[i*8 +: 8]    = 8'd3;
      vecs[1].exp[i*PW +: PW] = 16'd18;
      vecs[2].a[i*8 +: 8]    = 8'($urandom_range(15, 0));
      vecs[2].b[i*8 +: 8]    = 8'($urandom_range(15, 0));
      vecs[3].a[i*8 +: 8]    = 8'($urandom_range(255, 0));
      vecs[3].b[i*8 +: 8]    = 8'($urandom_range(255, 0));
    end
    vecs[2].exp = mm(vecs[2].a, vecs[2].b);
    vecs[3].exp = mm(vecs[3].a, vecs[3].b);

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_arr_start", arr_start, 0);
    chk("rst_arr_a", arr_a, 0);
    chk("rst_arr_b", arr_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_mat", res_mat, 0);
    #5 RSTn = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // Table-driven operations with skew checks over FEED
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].a, vecs[v].b, vecs[v].exp, 1'b0);
      for (int t = 0; t < 5; t++) begin
        chk("feed_arr_start", arr_start, 1);
        chk("feed_in_ready", in_ready, 0);
        chk("feed_arr_a", arr_a, skew(vecs[v].a, t, 1'b0));
        chk("feed_arr_b", arr_b, skew(vecs[v].b, t, 1'b1));
        if (v == 1) begin
          chk("lane0_seq", arr_a[7:0], lane0_exp[t]);
          chk("lane2_seq", arr_a[23:16], lane2_exp[t]);
        end
        if (t < 4) tick();
      end
      tick();
      chk("wait_arr_a", arr_a, 0);
      chk("wait_arr_b", arr_b, 0);
      chk("wait_arr_start", arr_start, 1);
      wait_res(40);
      take();
    end

    // Consumer stall: result held stable for 10 cycles
    send(vecs[2].a, vecs[2].b, vecs[2].exp, 1'b0);
    wait_res(40);
    chk("hold_arr_start", arr_start, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", res_valid, 1);
      chk("stall_mat", res_mat, vecs[2].exp);
      chk("stall_in_ready", in_ready, 0);
    end
    take();

    // Capture timeout: no strobes at all
    model_en = 1'b0; man_v = 5'd0;
    send(vecs[1].a, vecs[1].b, '0, 1'b1);
    n = 0;
    while (!res_valid && n < 60) begin tick(); n++; end
    chk("timeout_latency", n, 21);
    take();

    // Burst of all strobes in one WAIT cycle plus an earlier duplicate P11
    send(vecs[0].a, vecs[0].b, '0, 1'b0);
    void'(exp_q.pop_back());
    void'(err_q.pop_back());
    tick(); tick(); tick();
    man_v = 5'b00001;
    for (int i = 0; i < 9; i++) man_p[i*PW +: PW] = 16'h7777;
    man_p[15:0] = 16'h1111;
    tick();
    man_v = 5'd0;
    tick();
    tick();
    chk("burst_pre_valid", res_valid, 0);
    for (int i = 0; i < 9; i++) man_p[i*PW +: PW] = 16'hA000 + 16'(i);
    man_v = 5'b11111;
    tick();
    man_v = 5'd0;
    chk("burst_hold_next", res_valid, 1);
    e = '0;
    for (int i = 0; i < 9; i++) e[i*PW +: PW] = 16'hA000 + 16'(i);
    e[15:0] = 16'h1111;
    exp_q.push_back(e);
    err_q.push_back(1'b0);
    take();
    model_en = 1'b1;

    // Asynchronous reset in the middle of FEED
    send(vecs[3].a, vecs[3].b, vecs[3].exp, 1'b0);
    tick(); tick();
    RSTn = 1'b0;
    #1;
    chk("midrst_arr_start", arr_start, 0);
    chk("midrst_arr_a", arr_a, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    exp_q.delete();
    err_q.delete();
    tick(); tick();
    RSTn = 1'b1;
    tick();
    chk("midrst_rel_ready", in_ready, 1);
    send(vecs[2].a, vecs[2].b, vecs[2].exp, 1'b0);
    wait_res(40);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
